// File: rtl/instr_fetch_decode.sv
// Instruction fetch FSM with a held instruction register and branch/jump decode.
// A fetch that sees no memory ack within WAIT_LIMIT cycles locks up in FAULT until reset.
module instr_fetch_decode #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        zero,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] extended_immediate,
    output logic [31:0] jump_address,
    output logic        select_branch,
    output logic        sign_jump,
    output logic        busy,
    output logic        fault
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LIMIT - 1);

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FAULT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          req_n;
    logic [31:0]   addr_n;
    logic [31:0]   instr_n;
    logic          fault_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= 32'd0;
            instruction <= 32'd0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            instruction <= instr_n;
            fault       <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = imem_req;
        addr_n  = imem_addr;
        instr_n = instruction;
        fault_n = fault;
        unique case (state)
            IDLE: begin
                if (pc_valid) begin
                    state_n = REQ;
                    addr_n  = pc;
                    req_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            REQ: begin
                // A late ack on the final wait cycle still completes the fetch.
                if (imem_ack) begin
                    state_n = HOLD;
                    instr_n = imem_data;
                    req_n   = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_n = FAULT;
                    req_n   = 1'b0;
                    fault_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (pc_valid) begin
                        state_n = REQ;
                        addr_n  = pc;
                        req_n   = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            FAULT: begin
                req_n   = 1'b0;
                fault_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    logic [5:0] opcode;
    logic [5:0] jump_hi;
    logic       is_jump;
    logic       take_branch;

    assign opcode      = instruction[31:26];
    assign instr_valid = (state == HOLD);
    assign busy        = (state != IDLE);

    // Upper six bits of imem_addr + 1, wrapping modulo 2^32.
    assign jump_hi = imem_addr[31:26] + {5'd0, &imem_addr[25:0]};

    assign jump_address       = {jump_hi, instruction[25:0]};
    assign extended_immediate = {{16{instruction[15]}}, instruction[15:0]};

    assign is_jump     = (opcode == OP_J) || (opcode == OP_JAL);
    assign take_branch = ((opcode == OP_BEQ) && zero)
                       || ((opcode == OP_BNE) && !zero);

    assign sign_jump     = instr_valid && is_jump;
    assign select_branch = instr_valid && take_branch && !is_jump;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized and directed bench for instr_fetch_decode.
// A transaction-level reference model predicts every output each cycle.
module tb_instr_fetch_decode;

    localparam int WL = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        zero;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] extended_immediate;
    logic [31:0] jump_address;
    logic        select_branch;
    logic        sign_jump;
    logic        busy;
    logic        fault;

    instr_fetch_decode #(.WAIT_LIMIT(WL)) dut (
        .clock              (clock),
        .reset              (reset),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_data          (imem_data),
        .zero               (zero),
        .instr_ready        (instr_ready),
        .instruction        (instruction),
        .instr_valid        (instr_valid),
        .extended_immediate (extended_immediate),
        .jump_address       (jump_address),
        .select_branch      (select_branch),
        .sign_jump          (sign_jump),
        .busy               (busy),
        .fault              (fault)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one outstanding fetch, one held word, a dead flag.
    bit        m_out;
    int        m_waited;
    bit        m_have;
    bit        m_dead;
    bit [31:0] m_addr;
    bit [31:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_fetch(input bit [31:0] a);
        m_out    = 1'b1;
        m_waited = 0;
        m_addr   = a;
    endtask

    task automatic model_edge();
        if (reset) begin
            m_out    = 1'b0;
            m_waited = 0;
            m_have   = 1'b0;
            m_dead   = 1'b0;
            m_addr   = 32'd0;
            m_instr  = 32'd0;
        end else if (m_dead) begin
            m_dead = 1'b1;
        end else if (m_out) begin
            if (imem_ack) begin
                m_instr = imem_data;
                m_have  = 1'b1;
                m_out   = 1'b0;
            end else if (m_waited + 1 >= WL) begin
                m_dead = 1'b1;
                m_out  = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (m_have) begin
            if (instr_ready) begin
                m_have = 1'b0;
                if (pc_valid) start_fetch(pc);
            end
        end else if (pc_valid) begin
            start_fetch(pc);
        end
    endtask

    task automatic check_all(input string tag);
        int        op;
        bit        is_j;
        bit [31:0] e_ext;
        bit [31:0] e_jmp;
        bit        e_sel;
        op    = int'(m_instr >> 26);
        is_j  = (op == 2) || (op == 3);
        e_sel = m_have && ((op == 4 && zero) || (op == 5 && !zero));
        e_ext = m_instr[15] ? (m_instr | 32'hFFFF0000)
                            : (m_instr & 32'h0000FFFF);
        e_jmp = ((m_addr + 32'd1) & 32'hFC000000)
              | (m_instr & 32'h03FFFFFF);
        chk({tag, ".req"},   32'(imem_req),    32'(m_out));
        chk({tag, ".addr"},  imem_addr,        m_addr);
        chk({tag, ".instr"}, instruction,      m_instr);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(m_have));
        chk({tag, ".busy"},  32'(busy),        32'(m_out | m_have | m_dead));
        chk({tag, ".fault"}, 32'(fault),       32'(m_dead));
        chk({tag, ".ext"},   extended_immediate, e_ext);
        chk({tag, ".jmp"},   jump_address,     e_jmp);
        chk({tag, ".sj"},    32'(sign_jump),   32'(m_have && is_j));
        chk({tag, ".sel"},   32'(select_branch), 32'(e_sel));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic r, input logic pv, input logic [31:0] p,
                         input logic ak, input logic [31:0] d,
                         input logic rdy, input logic z);
        reset       = r;
        pc_valid    = pv;
        pc          = p;
        imem_ack    = ak;
        imem_data   = d;
        instr_ready = rdy;
        zero        = z;
    endtask

    initial begin
        bit [31:0] rnd;
        bit [31:0] data;
        bit [5:0]  ops [5];
        ops[0] = 6'b000100;
        ops[1] = 6'b000101;
        ops[2] = 6'b000010;
        ops[3] = 6'b000011;
        ops[4] = 6'b100011;

        drive(1, 0, 0, 0, 0, 0, 0);
        tick("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // beq fetch with ack on cycle 3
        drive(0, 1, 32'd5, 0, 0, 0, 1);
        tick("f_c1");
        chk("f_addr", imem_addr, 32'd5);
        chk("f_req", 32'(imem_req), 32'd1);
        pc_valid = 0;
        tick("f_c2");
        tick("f_c3");
        imem_ack  = 1;
        imem_data = 32'h1085FFFE;
        tick("f_c4");
        imem_ack = 0;
        chk("f_valid", 32'(instr_valid), 32'd1);
        chk("f_sel", 32'(select_branch), 32'd1);
        chk("f_ext", extended_immediate, 32'hFFFFFFFE);

        // back-to-back from HOLD
        instr_ready = 1;
        pc_valid    = 1;
        pc          = 32'd9;
        tick("b2b");
        instr_ready = 0;
        pc_valid    = 0;
        chk("b2b_req", 32'(imem_req), 32'd1);
        chk("b2b_addr", imem_addr, 32'd9);
        chk("b2b_valid", 32'(instr_valid), 32'd0);

        // bne follows zero combinationally while held
        imem_ack  = 1;
        imem_data = 32'h14850003;
        zero      = 1;
        tick("bne");
        imem_ack = 0;
        chk("bne_z1", 32'(select_branch), 32'd0);
        zero = 0;
        #1;
        check_all("bne_z0");
        chk("bne_z0_sel", 32'(select_branch), 32'd1);

        // j decode
        instr_ready = 1;
        pc_valid    = 1;
        pc          = 32'h0C000010;
        tick("j_req");
        instr_ready = 0;
        pc_valid    = 0;
        imem_ack    = 1;
        imem_data   = 32'h08000100;
        tick("j_hold");
        imem_ack = 0;
        chk("j_sj", 32'(sign_jump), 32'd1);
        chk("j_sel", 32'(select_branch), 32'd0);
        chk("j_addr", jump_address, 32'h0C000100);

        // jal at the top of the address space: addr+1 wraps
        instr_ready = 1;
        pc_valid    = 1;
        pc          = 32'hFFFFFFFF;
        tick("w_req");
        instr_ready = 0;
        pc_valid    = 0;
        imem_ack    = 1;
        imem_data   = 32'h0C000123;
        tick("w_hold");
        imem_ack = 0;
        chk("wrap_jmp", jump_address, 32'h00000123);

        // reset while REQ sees an ack
        instr_ready = 1;
        pc_valid    = 1;
        pc          = 32'd7;
        tick("r_req");
        drive(1, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tick("r_rst");
        chk("rmid_instr", instruction, 32'd0);
        chk("rmid_req", 32'(imem_req), 32'd0);
        chk("rmid_busy", 32'(busy), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // ack on the last permitted wait cycle beats the timeout
        pc_valid = 1;
        pc       = 32'd3;
        tick("late_req");
        pc_valid = 0;
        repeat (WL - 1) tick("late_wait");
        imem_ack  = 1;
        imem_data = 32'h10000001;
        tick("late_ack");
        imem_ack = 0;
        chk("late_valid", 32'(instr_valid), 32'd1);
        chk("late_fault", 32'(fault), 32'd0);
        instr_ready = 1;
        tick("late_rel");
        instr_ready = 0;

        // timeout into sticky FAULT
        pc_valid = 1;
        pc       = 32'd4;
        tick("to_req");
        pc_valid = 0;
        repeat (WL - 1) tick("to_wait");
        chk("to_pre_req", 32'(imem_req), 32'd1);
        chk("to_pre_fault", 32'(fault), 32'd0);
        tick("to_fault");
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req", 32'(imem_req), 32'd0);
        pc_valid = 1;
        imem_ack = 1;
        repeat (3) tick("to_stick");
        chk("to_stick_fault", 32'(fault), 32'd1);
        chk("to_stick_req", 32'(imem_req), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("to_rst");
        reset = 0;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rnd  = $urandom();
            data = {ops[$urandom_range(0, 4)], rnd[25:0]};
            reset       = ($urandom_range(0, 149) == 0);
            pc_valid    = ($urandom_range(0, 1) == 0);
            imem_ack    = ($urandom_range(0, 3) == 0);
            imem_data   = data;
            instr_ready = ($urandom_range(0, 2) == 0);
            zero        = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       pc = 32'hFFFFFFFF;
                1:       pc = 32'h03FFFFFF;
                default: pc = $urandom();
            endcase
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
